// File: rtl/uart_prog_loader.sv
// UART boot loader: receives a framed program image and writes it into IMem.
// Holds the CPU in reset until the whole image has been written.
module uart_prog_loader #(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 115200,
  parameter int ADDR_W   = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uart_rx,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              frame_err
);

  localparam int CPB  = CLK_FREQ / BAUD;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB + 1);
  localparam int IW   = ADDR_W + 1;

  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_START = 2'd1;
  localparam logic [1:0] R_DATA  = 2'd2;
  localparam logic [1:0] R_STOP  = 2'd3;

  localparam logic [2:0] L_SYNC = 3'd0;
  localparam logic [2:0] L_CLO  = 3'd1;
  localparam logic [2:0] L_CHI  = 3'd2;
  localparam logic [2:0] L_DATA = 3'd3;
  localparam logic [2:0] L_DONE = 3'd4;

  localparam logic [7:0] SYNC_B = 8'hA5;

  logic          r_rx_s1;
  logic          r_rx_s2;
  logic          r_rx_d;
  logic [1:0]    r_rx_st;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_bv;
  logic          r_serr;

  logic [2:0]        r_ld_st;
  logic [15:0]       r_n;
  logic [IW-1:0]     r_widx;
  logic [1:0]        r_bidx;
  logic [31:0]       r_word;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_hold;
  logic              r_done;
  logic              r_ferr;

  logic [15:0] w_n;
  logic [31:0] w_word;
  logic        w_last;
  logic        w_big;

  assign w_n    = {r_shift, r_n[7:0]};
  assign w_word = {r_shift, r_word[31:8]};
  assign w_last = (32'(r_widx) + 32'd1) == 32'(r_n);
  assign w_big  = 32'(w_n) > (32'd1 << ADDR_W);

  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign cpu_hold   = r_hold;
  assign load_done  = r_done;
  assign frame_err  = r_ferr;

  // Two-flop synchronizer plus delayed copy for falling-edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
      r_rx_d  <= 1'b1;
    end else begin
      r_rx_s1 <= uart_rx;
      r_rx_s2 <= r_rx_s1;
      r_rx_d  <= r_rx_s2;
    end
  end

  // UART 8N1 receiver: mid-bit sampling, one-cycle byte/error pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_st <= R_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_bv    <= 1'b0;
      r_serr  <= 1'b0;
    end else begin
      r_bv   <= 1'b0;
      r_serr <= 1'b0;
      case (r_rx_st)
        R_IDLE: begin
          if (r_rx_d && !r_rx_s2) begin
            r_rx_st <= R_START;
            r_cnt   <= '0;
          end
        end
        R_START: begin
          if (r_cnt == CW'(HALF - 1)) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_rx_st <= r_rx_s2 ? R_IDLE : R_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        R_DATA: begin
          if (r_cnt == CW'(CPB - 1)) begin
            r_cnt   <= '0;
            r_shift <= {r_rx_s2, r_shift[7:1]};
            r_bit   <= r_bit + 1'b1;
            if (r_bit == 3'd7) r_rx_st <= R_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          if (r_cnt == CW'(CPB - 1)) begin
            r_cnt   <= '0;
            r_rx_st <= R_IDLE;
            if (r_rx_s2) r_bv <= 1'b1;
            else         r_serr <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // Frame parser: sync, count, little-endian words, IMem write strobes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ld_st <= L_SYNC;
      r_n     <= '0;
      r_widx  <= '0;
      r_bidx  <= '0;
      r_word  <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_hold  <= 1'b1;
      r_done  <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_we   <= 1'b0;
      r_ferr <= 1'b0;
      if (r_ld_st == L_DONE) begin
        r_hold <= 1'b0;
        r_done <= 1'b1;
      end
      if (r_serr) begin
        r_ferr <= 1'b1;
        if (r_ld_st != L_SYNC && r_ld_st != L_DONE) begin
          r_ld_st <= L_SYNC;
          r_bidx  <= '0;
        end
      end else if (r_bv) begin
        case (r_ld_st)
          L_SYNC: begin
            if (r_shift == SYNC_B) r_ld_st <= L_CLO;
          end
          L_CLO: begin
            r_n[7:0] <= r_shift;
            r_ld_st  <= L_CHI;
          end
          L_CHI: begin
            r_n[15:8] <= r_shift;
            if (w_n == 16'd0) begin
              r_ld_st <= L_DONE;
            end else if (w_big) begin
              r_ferr  <= 1'b1;
              r_ld_st <= L_SYNC;
            end else begin
              r_widx  <= '0;
              r_bidx  <= '0;
              r_ld_st <= L_DATA;
            end
          end
          L_DATA: begin
            r_word <= w_word;
            r_bidx <= r_bidx + 1'b1;
            if (r_bidx == 2'd3) begin
              r_we    <= 1'b1;
              r_addr  <= r_widx[ADDR_W-1:0];
              r_wdata <= w_word;
              r_widx  <= r_widx + 1'b1;
              if (w_last) r_ld_st <= L_DONE;
            end
          end
          L_DONE: begin
            if (r_shift == SYNC_B) begin
              r_ld_st <= L_CLO;
              r_hold  <= 1'b1;
              r_done  <= 1'b0;
            end
          end
          default: r_ld_st <= L_SYNC;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Bench for uart_prog_loader at 16 clocks per bit.
// Expected IMem writes are queued as bytes are sent and popped on each strobe.
module tb_uart_prog_loader;

  localparam int AW = 14;
  localparam int CPB = 16;

  typedef struct packed {
    logic          last;
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          uart_rx = 1'b1;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_hold;
  logic          load_done;
  logic          frame_err;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   ferr_cnt = 0;
  int   f0;
  bit   rel_pend = 0;

  uart_prog_loader #(
    .CLK_FREQ(1600000),
    .BAUD    (100000),
    .ADDR_W  (AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .uart_rx   (uart_rx),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (imem_we) chk("we_in_rst", {63'd0, imem_we}, 64'd0);
    end else begin
      if (frame_err) ferr_cnt++;
      if (rel_pend) begin
        chk("hold_rel", {63'd0, cpu_hold}, 64'd0);
        chk("done_rel", {63'd0, load_done}, 64'd1);
        rel_pend = 0;
      end
      if (imem_we) begin
        if (sb.size() == 0) begin
          chk("unexp_we", {63'd0, imem_we}, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("we_addr", 64'(imem_addr), 64'(e.addr));
          chk("we_data", 64'(imem_wdata), 64'(e.data));
          if (e.last) begin
            chk("hold_at_we", {63'd0, cpu_hold}, 64'd1);
            rel_pend = 1;
          end
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit stop_ok = 1);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop_ok;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_word(input logic [AW-1:0] a, input logic [31:0] d,
                           input bit last);
    sb.push_back('{last: last, addr: a, data: d});
    for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (5) @(negedge clk);
    uart_rx = 1'b1;
    rst = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    // Reset with rx toggling
    for (int i = 0; i < 40; i++) begin
      uart_rx = i[0];
      @(negedge clk);
    end
    uart_rx = 1'b1;
    chk("rst_hold", {63'd0, cpu_hold}, 64'd1);
    chk("rst_done", {63'd0, load_done}, 64'd0);
    chk("rst_addr", 64'(imem_addr), 64'd0);
    chk("rst_wdata", 64'(imem_wdata), 64'd0);
    chk("rst_ferr", {63'd0, frame_err}, 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // Two-word frame
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
    send_word(0, 32'h00000013, 0);
    send_word(1, 32'h000102B7, 1);
    repeat (4) @(negedge clk);
    chk("a_sb_empty", 64'(sb.size()), 64'd0);
    chk("a_hold", {63'd0, cpu_hold}, 64'd0);
    chk("a_done", {63'd0, load_done}, 64'd1);
    chk("a_addr_hold", 64'(imem_addr), 64'd1);

    // Reload from DONE
    send_byte(8'hA5);
    chk("reload_hold", {63'd0, cpu_hold}, 64'd1);
    chk("reload_done", {63'd0, load_done}, 64'd0);
    send_byte(8'h01); send_byte(8'h00);
    send_word(0, 32'hCAFEF00D, 1);
    repeat (4) @(negedge clk);
    chk("reload_sb", 64'(sb.size()), 64'd0);

    // Junk and a start glitch before sync
    do_reset();
    uart_rx = 1'b0;
    repeat (3) @(negedge clk);
    uart_rx = 1'b1;
    repeat (20) @(negedge clk);
    send_byte(8'h00); send_byte(8'hFF);
    chk("junk_hold", {63'd0, cpu_hold}, 64'd1);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    send_word(0, 32'hDEADBEEF, 1);
    repeat (4) @(negedge clk);
    chk("junk_sb", 64'(sb.size()), 64'd0);
    chk("junk_done", {63'd0, load_done}, 64'd1);

    // Stop-bit error on the second data byte
    do_reset();
    f0 = ferr_cnt;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22, 0);
    send_byte(8'h33); send_byte(8'h44);
    chk("stop_ferr", 64'(ferr_cnt - f0), 64'd1);
    chk("stop_hold", {63'd0, cpu_hold}, 64'd1);
    chk("stop_done", {63'd0, load_done}, 64'd0);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    send_word(0, 32'h12345678, 1);
    repeat (4) @(negedge clk);
    chk("stop_sb", 64'(sb.size()), 64'd0);
    chk("stop_rec", {63'd0, load_done}, 64'd1);

    // Zero count reload
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
    repeat (4) @(negedge clk);
    chk("n0_done", {63'd0, load_done}, 64'd1);
    chk("n0_hold", {63'd0, cpu_hold}, 64'd0);

    // Oversized count
    f0 = ferr_cnt;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h40);
    chk("big_ferr", 64'(ferr_cnt - f0), 64'd1);
    chk("big_hold", {63'd0, cpu_hold}, 64'd1);
    chk("big_done", {63'd0, load_done}, 64'd0);

    // Async reset in the middle of a word
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'hAA);
    uart_rx = 1'b0;
    repeat (40) @(negedge clk);
    #3 rst = 1'b0;
    #1;
    chk("mid_rst_hold", {63'd0, cpu_hold}, 64'd1);
    chk("mid_rst_addr", 64'(imem_addr), 64'd0);
    repeat (3) @(negedge clk);
    uart_rx = 1'b1;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    send_word(0, 32'h04030201, 1);
    repeat (4) @(negedge clk);
    chk("mid_sb", 64'(sb.size()), 64'd0);
    chk("mid_done", {63'd0, load_done}, 64'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
